rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over the shared datapath: PC, IR, register file, immediate decoder, ALU, branch-target adder and a single memory port.
- Drives all datapath enables and selects from IR opcode bits and memory handshake inputs.
- Counts retired instructions and halts on SYSTEM, illegal opcode or bus timeout.

Parameters:
MEM_TIMEOUT, 255, max wait cycles for mem_ready on one request before bus error (1..255)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0], valid from DECODE onward
branch_taken  in  1  ALU compare result, valid in EXEC of a branch
mem_ready  in  1  memory accepts/completes current request this cycle
mem_req  out  1  memory request valid
mem_we  out  1  1 = store, 0 = read
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_we  out  1  load IR from memory read data
pc_we  out  1  update PC
pc_src  out  2  0 = PC+4, 1 = PC+imm, 2 = {alu[31:1],1'b0}
alu_a_sel  out  2  0 = rs1, 1 = PC, 2 = zero
alu_b_sel  out  1  0 = rs2, 1 = imm
alu_op  out  2  0 = add, 1 = funct3/funct7 driven, 2 = branch compare
rf_we  out  1  register file write
wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
instret  out  32  retired-instruction count
halted  out  1  FSM in HALT
illegal  out  1  halt cause: unknown opcode
bus_error  out  1  halt cause: memory timeout
state  out  3  current state encoding, debug

Behaviour:
- States (encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Other encodings go to HALT with illegal=1.
- Reset (async, rst_n=0):
  - state=FETCH; instret=0; halted, illegal, bus_error=0.
  - All strobes (mem_req, ir_we, pc_we, rf_we) are 0 immediately, including when reset hits mid-request.
  - First request is issued in the first cycle after release.
- Default outputs in every state are 0 unless listed below.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - mem_ready=1 -> ir_we=1, next DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - One cycle; register file read and immediate decode settle.
  - Next EXEC for LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, MISC-MEM 0001111.
  - SYSTEM 1110011 -> HALT.
  - Any other opcode -> HALT with illegal=1.
- EXEC, per opcode (retire = pc_we=1 and instret+1 in that cycle):
  - OP: alu_a=0, alu_b=0, alu_op=1, rf_we=1, wb_sel=0, pc_src=0. Retire; next FETCH.
  - OP-IMM: same as OP but alu_b=1.
  - LUI: alu_a=2, alu_b=1, alu_op=0, rf_we=1, wb_sel=0. Retire.
  - AUIPC: alu_a=1, alu_b=1, alu_op=0, rf_we=1, wb_sel=0. Retire.
  - JAL: rf_we=1, wb_sel=2, pc_src=1. Retire.
  - JALR: alu_a=0, alu_b=1, alu_op=0, rf_we=1, wb_sel=2, pc_src=2. Retire.
  - BRANCH: alu_a=0, alu_b=0, alu_op=2, pc_src = branch_taken ? 1 : 0. Retire.
  - MISC-MEM: no-op, pc_src=0. Retire.
  - LOAD/STORE: alu_a=0, alu_b=1, alu_op=0 (address). Next MEM; no retire.
- MEM:
  - mem_req=1, mem_addr_sel=1, alu_a=0, alu_b=1, alu_op=0 held stable; mem_we=1 for STORE.
  - Wait for mem_ready.
  - STORE: on mem_ready, retire (pc_src=0), next FETCH.
  - LOAD: on mem_ready, next WB.
- WB (LOAD only): rf_we=1, wb_sel=1, pc_src=0. Retire; next FETCH.
- HALT:
  - Absorbing until reset; halted=1; all strobes 0.
  - illegal and bus_error hold their values.
- Handshake:
  - mem_req, mem_we and mem_addr_sel stay constant from assertion until the cycle mem_ready=1.
  - mem_req drops the cycle after acceptance unless a new request state follows.
  - mem_ready is ignored while mem_req=0.
- Timeout:
  - 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 and mem_ready=0.
  - When the count reaches MEM_TIMEOUT with mem_ready=0 -> HALT with bus_error=1.
  - If mem_ready=1 in that same cycle, the handshake completes normally and no error is raised.
- instret: 32-bit, wraps 0xFFFFFFFF -> 0; increments exactly once per retired instruction.
- Latency with zero-wait memory:
  - ALU, jump and branch instructions: 3 cycles.
  - Stores: 4 cycles.
  - Loads: 5 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset release, mem_ready tied 1, opcode=0110011 -> states 0,1,2,0; ir_we in cycle 1; rf_we=pc_we=1 in cycle 3; instret=1.
- LOAD with mem_ready low 3 cycles in MEM -> mem_req, mem_we=0, mem_addr_sel=1 stable 4 cycles; WB rf_we=1, wb_sel=1; 8 cycles total; instret=1.
- BRANCH, branch_taken=1 then 0 -> EXEC pc_src=1 then 0, rf_we=0, pc_we=1 both times.
- Opcode 1111111 -> HALT, illegal=1, halted=1; no further mem_req for 20 cycles; instret unchanged.
- MEM_TIMEOUT=4, mem_ready never rises in FETCH -> HALT after 4 wait cycles, bus_error=1, mem_req=0; repeat with mem_ready=1 on the 4th cycle -> DECODE, no error.
- Assert rst_n=0 mid-MEM of a STORE -> mem_req=0 immediately; state=0, instret=0; after release, FETCH mem_req=1 with mem_addr_sel=0; preload instret to 0xFFFFFFFF via 2^32-1 retires is impractical, so force-deposit 0xFFFFFFFF, retire one -> 0.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode, execute, memory and
// writeback over the shared datapath, counts retired instructions and halts on fatal conditions.
module rv_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] instret,
    output logic        halted,
    output logic        illegal,
    output logic        bus_error,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_t;

    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpImm     = 7'b0010011;
    localparam logic [6:0] OpReg     = 7'b0110011;
    localparam logic [6:0] OpMiscMem = 7'b0001111;
    localparam logic [6:0] OpSystem  = 7'b1110011;

    localparam logic [8:0] TimeoutCnt = 9'(MEM_TIMEOUT);

    state_t      state_q;
    logic [31:0] instret_q;
    logic [7:0]  wait_q;
    logic        illegal_q;
    logic        bus_error_q;
    logic        retire;
    logic        is_store;
    logic        is_mem_op;
    logic        timeout;

    assign is_store  = (opcode == OpStore);
    assign is_mem_op = is_store || (opcode == OpLoad);
    // Fires on the wait cycle that would bring the count to MEM_TIMEOUT; a late ready still wins.
    assign timeout   = mem_req && !mem_ready && (({1'b0, wait_q} + 9'd1) == TimeoutCnt);

    // Outputs are gated by rst_n so every strobe drops the instant reset asserts.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_src       = 2'd0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 1'b0;
        alu_op       = 2'd0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        retire       = 1'b0;
        if (rst_n) begin
            case (state_q)
                StFetch: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                StExec: begin
                    case (opcode)
                        OpReg: begin
                            alu_op = 2'd1;
                            rf_we  = 1'b1;
                            retire = 1'b1;
                        end
                        OpImm: begin
                            alu_b_sel = 1'b1;
                            alu_op    = 2'd1;
                            rf_we     = 1'b1;
                            retire    = 1'b1;
                        end
                        OpLui: begin
                            alu_a_sel = 2'd2;
                            alu_b_sel = 1'b1;
                            rf_we     = 1'b1;
                            retire    = 1'b1;
                        end
                        OpAuipc: begin
                            alu_a_sel = 2'd1;
                            alu_b_sel = 1'b1;
                            rf_we     = 1'b1;
                            retire    = 1'b1;
                        end
                        OpJal: begin
                            rf_we  = 1'b1;
                            wb_sel = 2'd2;
                            pc_src = 2'd1;
                            retire = 1'b1;
                        end
                        OpJalr: begin
                            alu_b_sel = 1'b1;
                            rf_we     = 1'b1;
                            wb_sel    = 2'd2;
                            pc_src    = 2'd2;
                            retire    = 1'b1;
                        end
                        OpBranch: begin
                            alu_op = 2'd2;
                            pc_src = branch_taken ? 2'd1 : 2'd0;
                            retire = 1'b1;
                        end
                        OpMiscMem: retire = 1'b1;
                        OpLoad, OpStore: alu_b_sel = 1'b1;
                        default: ;
                    endcase
                end
                StMem: begin
                    mem_req      = 1'b1;
                    mem_we       = is_store;
                    mem_addr_sel = 1'b1;
                    alu_b_sel    = 1'b1;
                    retire       = is_store && mem_ready;
                end
                StWb: begin
                    rf_we  = 1'b1;
                    wb_sel = 2'd1;
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
        pc_we = retire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFetch;
            instret_q   <= 32'd0;
            wait_q      <= 8'd0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
            // Counter is zero whenever no request is outstanding, so entry to FETCH/MEM sees 0.
            if (mem_req && !mem_ready) begin
                wait_q <= wait_q + 8'd1;
            end else begin
                wait_q <= 8'd0;
            end
            case (state_q)
                StFetch: begin
                    if (mem_ready) begin
                        state_q <= StDecode;
                    end else if (timeout) begin
                        state_q     <= StHalt;
                        bus_error_q <= 1'b1;
                    end
                end
                StDecode: begin
                    case (opcode)
                        OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad, OpStore, OpImm, OpReg,
                        OpMiscMem: state_q <= StExec;
                        OpSystem:  state_q <= StHalt;
                        default: begin
                            state_q   <= StHalt;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                StExec: state_q <= is_mem_op ? StMem : StFetch;
                StMem: begin
                    if (mem_ready) begin
                        state_q <= is_store ? StFetch : StWb;
                    end else if (timeout) begin
                        state_q     <= StHalt;
                        bus_error_q <= 1'b1;
                    end
                end
                StWb:   state_q <= StFetch;
                StHalt: state_q <= StHalt;
                default: begin
                    state_q   <= StHalt;
                    illegal_q <= 1'b1;
                end
            endcase
        end
    end

    assign instret   = instret_q;
    assign halted    = (state_q == StHalt);
    assign illegal   = illegal_q;
    assign bus_error = bus_error_q;
    assign state     = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: stimulus pushes per-cycle expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_rv_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        branch_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_b_sel, rf_we;
    logic [1:0]  pc_src, alu_a_sel, alu_op, wb_sel;
    logic [31:0] instret;
    logic        halted, illegal, bus_error;
    logic [2:0]  state;

    rv_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .alu_op       (alu_op),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .instret      (instret),
        .halted       (halted),
        .illegal      (illegal),
        .bus_error    (bus_error),
        .state        (state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OpLui = 7'b0110111, OpAuipc = 7'b0010111, OpJal = 7'b1101111;
    localparam logic [6:0] OpJalr = 7'b1100111, OpBranch = 7'b1100011, OpLoad = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011, OpImm = 7'b0010011, OpReg = 7'b0110011;
    localparam logic [6:0] OpMisc = 7'b0001111, OpSystem = 7'b1110011, OpBad = 7'b1111111;

    // -1 in any field means "don't care" for that cycle.
    typedef struct {
        string  name;
        int     st, req, we, asel, irw, pcw, pcs, aa, ab, aop, rfw, wbs, hlt, ill, berr;
        longint ins;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          passed = 0;
    logic [31:0] exp_ins = 32'd0;

    function automatic exp_t blank(input string n);
        exp_t e;
        e.name = n;
        e.st = -1; e.req = -1; e.we = -1; e.asel = -1; e.irw = -1; e.pcw = -1; e.pcs = -1;
        e.aa = -1; e.ab = -1; e.aop = -1; e.rfw = -1; e.wbs = -1; e.hlt = -1; e.ill = -1;
        e.berr = -1;
        e.ins = longint'(exp_ins);
        return e;
    endfunction

    function automatic void chk(input string f, input int want, input int got, inout string bad);
        if (want >= 0 && want != got) bad = {bad, $sformatf(" %s=%0d want %0d", f, got, want)};
    endfunction

    task automatic check_now(input string n, input logic cond);
        checks++;
        if (cond) passed++;
        else $display("FAIL %s: state=%0d mem_req=%0b halted=%0b bus_error=%0b instret=%0h",
                      n, state, mem_req, halted, bus_error, instret);
    endtask

    always @(negedge clk) begin : monitor
        exp_t  e;
        string bad;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            bad = "";
            chk("state", e.st, int'(state), bad);
            chk("mem_req", e.req, int'(mem_req), bad);
            chk("mem_we", e.we, int'(mem_we), bad);
            chk("mem_addr_sel", e.asel, int'(mem_addr_sel), bad);
            chk("ir_we", e.irw, int'(ir_we), bad);
            chk("pc_we", e.pcw, int'(pc_we), bad);
            chk("pc_src", e.pcs, int'(pc_src), bad);
            chk("alu_a_sel", e.aa, int'(alu_a_sel), bad);
            chk("alu_b_sel", e.ab, int'(alu_b_sel), bad);
            chk("alu_op", e.aop, int'(alu_op), bad);
            chk("rf_we", e.rfw, int'(rf_we), bad);
            chk("wb_sel", e.wbs, int'(wb_sel), bad);
            chk("halted", e.hlt, int'(halted), bad);
            chk("illegal", e.ill, int'(illegal), bad);
            chk("bus_error", e.berr, int'(bus_error), bad);
            if (e.ins >= 0 && e.ins != longint'(instret))
                bad = {bad, $sformatf(" instret=%0h want %0h", instret, e.ins)};
            checks++;
            if (bad == "") passed++;
            else $display("FAIL %s:%s", e.name, bad);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string n);
        exp_t e;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        exp_ins = 32'd0;
        #1;
        check_now({n, "_now"}, !mem_req && !ir_we && !pc_we && !rf_we && state == 3'd0 &&
                  instret == 32'd0);
        e = blank(n);
        e.st = 0; e.req = 0; e.irw = 0; e.pcw = 0; e.rfw = 0;
        e.hlt = 0; e.ill = 0; e.berr = 0;
        sbq.push_back(e);
        step();
        rst_n = 1'b1;
    endtask

    task automatic do_fetch(input string n, input logic rdy);
        exp_t e;
        mem_ready = rdy;
        e = blank(n);
        e.st = 0; e.req = 1; e.we = 0; e.asel = 0; e.irw = int'(rdy); e.pcw = 0; e.rfw = 0;
        e.hlt = 0;
        sbq.push_back(e);
        step();
    endtask

    task automatic do_decode(input string n, input logic [6:0] op);
        exp_t e;
        opcode = op;
        mem_ready = 1'b1;
        e = blank(n);
        e.st = 1; e.req = 0; e.irw = 0; e.pcw = 0; e.rfw = 0; e.hlt = 0;
        sbq.push_back(e);
        step();
    endtask

    task automatic do_exec(input string n, input int aa, input int ab, input int aop,
                           input int rfw, input int wbs, input int pcs, input int pcw);
        exp_t e;
        e = blank(n);
        e.st = 2; e.req = 0; e.irw = 0; e.aa = aa; e.ab = ab; e.aop = aop;
        e.rfw = rfw; e.wbs = wbs; e.pcs = pcs; e.pcw = pcw;
        sbq.push_back(e);
        if (pcw == 1) exp_ins = exp_ins + 32'd1;
        step();
    endtask

    task automatic do_mem(input string n, input logic rdy, input logic store);
        exp_t e;
        mem_ready = rdy;
        e = blank(n);
        e.st = 3; e.req = 1; e.we = int'(store); e.asel = 1; e.aa = 0; e.ab = 1; e.aop = 0;
        e.irw = 0; e.rfw = 0; e.pcw = int'(store & rdy);
        if (store & rdy) e.pcs = 0;
        sbq.push_back(e);
        if (store & rdy) exp_ins = exp_ins + 32'd1;
        step();
    endtask

    task automatic do_wb(input string n);
        exp_t e;
        e = blank(n);
        e.st = 4; e.req = 0; e.rfw = 1; e.wbs = 1; e.pcs = 0; e.pcw = 1;
        sbq.push_back(e);
        exp_ins = exp_ins + 32'd1;
        step();
    endtask

    task automatic do_halt(input string n, input int ill, input int berr);
        exp_t e;
        mem_ready = ~mem_ready;
        e = blank(n);
        e.st = 5; e.req = 0; e.irw = 0; e.pcw = 0; e.rfw = 0; e.hlt = 1; e.ill = ill;
        e.berr = berr;
        sbq.push_back(e);
        step();
    endtask

    task automatic run_alu(input string n, input logic [6:0] op, input int aa, input int ab,
                           input int aop, input int rfw, input int wbs, input int pcs);
        do_fetch(n, 1'b1);
        do_decode(n, op);
        do_exec(n, aa, ab, aop, rfw, wbs, pcs, 1);
    endtask

    initial begin
        step();
        do_reset("reset");

        run_alu("op", OpReg, 0, 0, 1, 1, 0, 0);

        // Load with three wait cycles; the 4th MEM cycle is also the timeout boundary.
        do_fetch("load", 1'b1);
        do_decode("load", OpLoad);
        do_exec("load_exec", 0, 1, 0, 0, -1, -1, 0);
        for (int i = 0; i < 3; i++) do_mem("load_wait", 1'b0, 1'b0);
        do_mem("load_ready", 1'b1, 1'b0);
        do_wb("load_wb");

        branch_taken = 1'b1;
        run_alu("br_taken", OpBranch, 0, 0, 2, 0, -1, 1);
        branch_taken = 1'b0;
        run_alu("br_not", OpBranch, 0, 0, 2, 0, -1, 0);

        do_fetch("store", 1'b1);
        do_decode("store", OpStore);
        do_exec("store_exec", 0, 1, 0, 0, -1, -1, 0);
        do_mem("store_mem", 1'b1, 1'b1);

        run_alu("jal", OpJal, -1, -1, -1, 1, 2, 1);
        run_alu("jalr", OpJalr, 0, 1, 0, 1, 2, 2);
        run_alu("lui", OpLui, 2, 1, 0, 1, 0, -1);
        run_alu("auipc", OpAuipc, 1, 1, 0, 1, 0, -1);
        run_alu("opimm", OpImm, 0, 1, 1, 1, 0, 0);
        run_alu("misc", OpMisc, -1, -1, -1, 0, -1, 0);

        // Reset arrives while a store request is outstanding.
        do_fetch("st_rst", 1'b1);
        do_decode("st_rst", OpStore);
        do_exec("st_rst_exec", 0, 1, 0, 0, -1, -1, 0);
        do_mem("st_rst_mem", 1'b0, 1'b1);
        do_reset("reset_mid_mem");
        do_fetch("post_reset_fetch", 1'b0);

        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        exp_ins = 32'hFFFF_FFFF;
        do_fetch("wrap", 1'b1);
        do_decode("wrap", OpReg);
        do_exec("wrap_exec", 0, 0, 1, 1, 0, 0, 1);
        do_fetch("wrap_after", 1'b0);

        do_reset("reset_to");
        for (int i = 0; i < 4; i++) do_fetch("to_wait", 1'b0);
        check_now("to_expired", state == 3'd5 && bus_error && halted && !mem_req);
        do_halt("to_halt", 0, 1);
        do_halt("to_halt_hold", 0, 1);

        do_reset("reset_to_edge");
        for (int i = 0; i < 3; i++) do_fetch("edge_wait", 1'b0);
        do_fetch("edge_ready", 1'b1);
        check_now("edge_no_error", state == 3'd1 && !bus_error);
        do_decode("system", OpSystem);
        do_halt("system_halt", 0, 0);

        do_reset("reset_ill");
        run_alu("pre_ill", OpReg, 0, 0, 1, 1, 0, 0);
        do_fetch("ill", 1'b1);
        do_decode("ill", OpBad);
        for (int i = 0; i < 20; i++) do_halt("ill_halt", 1, 0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
